// File: rtl/musicbox_pkg.sv
// Shared music box definitions: envelope state encodings, default step
// constants and the rest note code used by the tone generator.
package musicbox_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_t;

   localparam int STEP_DIV_DEF     = 50000;
   localparam int ATTACK_STEP_DEF  = 16;
   localparam int DECAY_STEP_DEF   = 4;
   localparam int SUSTAIN_LVL_DEF  = 160;
   localparam int RELEASE_STEP_DEF = 8;

   localparam logic [7:0] NOTE_REST = 8'd0;

endpackage

// File: rtl/env_pwm_gate.sv
// PWM gate: scales the envelope level by master volume and compares it
// against a free-running 8-bit ramp.
module env_pwm_gate (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] env_level,
   input  logic [1:0] vol_sel,
   output logic       gate
);

   logic [7:0] pwm_cnt;
   logic [7:0] level_eff;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pwm_cnt <= 8'd0;
      else      pwm_cnt <= pwm_cnt + 8'd1;
   end

   assign level_eff = env_level >> (2'd3 - vol_sel);

   // Full scale must be always-on; the plain compare would drop one slot.
   assign gate = (level_eff == 8'hFF) || (pwm_cnt < level_eff);

endmodule

// File: rtl/tone_envelope_pwm.sv
// Buzzer output stage: ADSR envelope retriggered on note changes, realised
// by PWM-gating the square-wave tone. The pin idles high.
module tone_envelope_pwm
   import musicbox_pkg::*;
#(
   parameter int STEP_DIV     = STEP_DIV_DEF,
   parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
   parameter int DECAY_STEP   = DECAY_STEP_DEF,
   parameter int SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
   parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tone_in,
   input  logic [7:0] note_code,
   input  logic [1:0] vol_sel,
   output logic       out,
   output logic [7:0] env_level,
   output logic       busy
);

   localparam logic [15:0] PRESC_MAX = 16'(STEP_DIV - 1);

   env_state_t  state, state_nx;
   logic [7:0]  level_nx;
   logic [15:0] prescaler;
   logic [7:0]  note_q;
   logic        tone_q;
   logic        tick, note_start, note_stop, gate;
   logic [8:0]  sum9, dec9, rel9;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tone_q <= 1'b1;
         note_q <= NOTE_REST;
      end else begin
         tone_q <= tone_in;
         note_q <= note_code;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      prescaler <= 16'd0;
      else if (tick) prescaler <= 16'd0;
      else           prescaler <= prescaler + 16'd1;
   end

   assign tick       = (prescaler == PRESC_MAX);
   assign note_start = (note_code != note_q) && (note_code != NOTE_REST);
   assign note_stop  = (note_code != note_q) && (note_code == NOTE_REST);

   // 9-bit intermediates so saturation is decided before truncation.
   assign sum9 = {1'b0, env_level} + 9'(ATTACK_STEP);
   assign dec9 = {1'b0, env_level} - 9'(DECAY_STEP);
   assign rel9 = {1'b0, env_level} - 9'(RELEASE_STEP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         env_level <= 8'd0;
      end else begin
         state     <= state_nx;
         env_level <= level_nx;
      end
   end

   always_comb begin
      state_nx = state;
      level_nx = env_level;
      // Note events take priority and swallow a coincident tick; the level
      // is kept so legato retriggers do not click.
      if (note_start) begin
         state_nx = ST_ATTACK;
      end else if (note_stop) begin
         if (state != ST_IDLE) state_nx = ST_RELEASE;
      end else if (tick) begin
         unique case (state)
            ST_ATTACK: begin
               if (sum9 >= 9'd255) begin
                  level_nx = 8'hFF;
                  state_nx = ST_DECAY;
               end else begin
                  level_nx = sum9[7:0];
               end
            end
            ST_DECAY: begin
               if (dec9[8] || (dec9 <= 9'(SUSTAIN_LVL))) begin
                  level_nx = 8'(SUSTAIN_LVL);
                  state_nx = ST_SUSTAIN;
               end else begin
                  level_nx = dec9[7:0];
               end
            end
            ST_RELEASE: begin
               if (rel9[8] || (rel9 == 9'd0)) begin
                  level_nx = 8'd0;
                  state_nx = ST_IDLE;
               end else begin
                  level_nx = rel9[7:0];
               end
            end
            default: ;
         endcase
      end
   end

   env_pwm_gate u_gate (
      .clk       (clk),
      .rst       (rst),
      .env_level (env_level),
      .vol_sel   (vol_sel),
      .gate      (gate)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) out <= 1'b1;
      else      out <= tone_q | ~gate | (note_q == NOTE_REST);
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// Directed bench for tone_envelope_pwm with a fast envelope tick.
module tb_tone_envelope_pwm;
   import musicbox_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tone_in = 1'b0;
   logic [7:0] note_code = 8'd0;
   logic [1:0] vol_sel = 2'd3;
   logic       out;
   logic [7:0] env_level;
   logic       busy;

   logic [7:0] g_lvl = 8'd0;
   logic [1:0] g_vol = 2'd3;
   logic       g_gate;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tone_envelope_pwm #(.STEP_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .tone_in   (tone_in),
      .note_code (note_code),
      .vol_sel   (vol_sel),
      .out       (out),
      .env_level (env_level),
      .busy      (busy)
   );

   env_pwm_gate u_ref_gate (
      .clk       (clk),
      .rst       (rst),
      .env_level (g_lvl),
      .vol_sel   (g_vol),
      .gate      (g_gate)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_chg(output logic [7:0] v, output int gap);
      logic [7:0] p;
      p = env_level;
      gap = 0;
      do begin
         step();
         gap++;
      end while (env_level === p && gap < 16);
      chk("chg_timeout", 16'(env_level !== p), 16'd1);
      v = env_level;
   endtask

   task automatic duty(output int n);
      n = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (out === 1'b0) n++;
      end
   endtask

   task automatic gcount(output int n);
      n = 0;
      for (int i = 0; i < 256; i++) begin
         step();
         if (g_gate === 1'b1) n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] v;
      int gap, n;

      #23;
      chk("rst_out", 16'(out), 16'd1);
      chk("rst_env", 16'(env_level), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      step();
      rst = 1'b1;

      for (int i = 0; i < 1000; i++) begin
         tone_in = 1'($urandom);
         step();
         chk("idle_out", 16'(out), 16'd1);
         chk("idle_env", 16'(env_level), 16'd0);
         chk("idle_busy", 16'(busy), 16'd0);
      end
      tone_in = 1'b0;

      note_code = 8'hEE;
      step();
      chk("start_busy", 16'(busy), 16'd1);
      chk("start_env", 16'(env_level), 16'd0);
      for (int k = 1; k <= 16; k++) begin
         wait_chg(v, gap);
         chk("atk_lvl", 16'(v), (k < 16) ? 16'(16 * k) : 16'd255);
         if (k > 1) chk("atk_gap", 16'(gap), 16'd4);
      end
      for (int k = 1; k <= 23; k++) begin
         wait_chg(v, gap);
         chk("dec_lvl", 16'(v), 16'(255 - 4 * k));
         chk("dec_gap", 16'(gap), 16'd4);
      end
      wait_chg(v, gap);
      chk("dec_clamp", 16'(v), 16'd160);
      step(20);
      chk("sus_hold", 16'(env_level), 16'd160);
      chk("sus_busy", 16'(busy), 16'd1);

      step(2);
      duty(n);
      chk("duty_v3", 16'(n), 16'd160);
      vol_sel = 2'd0;
      step(3);
      duty(n);
      chk("duty_v0", 16'(n), 16'd20);
      vol_sel = 2'd1;
      step(3);
      duty(n);
      chk("duty_v1", 16'(n), 16'd40);
      vol_sel = 2'd3;
      step(3);

      note_code = 8'h00;
      for (int k = 1; k <= 20; k++) begin
         wait_chg(v, gap);
         chk("rel_lvl", 16'(v), 16'(160 - 8 * k));
         chk("rel_out", 16'(out), 16'd1);
         if (k > 1) chk("rel_gap", 16'(gap), 16'd4);
      end
      chk("rel_idle_busy", 16'(busy), 16'd0);
      step(10);
      chk("rest_env", 16'(env_level), 16'd0);
      chk("rest_busy", 16'(busy), 16'd0);
      chk("rest_out", 16'(out), 16'd1);

      // Legato retrigger from mid-decay.
      note_code = 8'hEE;
      for (int k = 1; k <= 16; k++) wait_chg(v, gap);
      chk("leg_peak", 16'(v), 16'd255);
      for (int k = 1; k <= 13; k++) begin
         wait_chg(v, gap);
         chk("leg_dec", 16'(v), 16'(255 - 4 * k));
      end
      note_code = 8'h4D;
      step();
      chk("leg_keep", 16'(env_level), 16'd203);
      chk("leg_busy", 16'(busy), 16'd1);
      wait_chg(v, gap);
      chk("leg_a1", 16'(v), 16'd219);
      wait_chg(v, gap);
      chk("leg_a2", 16'(v), 16'd235);
      wait_chg(v, gap);
      chk("leg_a3", 16'(v), 16'd251);
      wait_chg(v, gap);
      chk("leg_a4", 16'(v), 16'd255);

      // Note stop exactly on the tick edge.
      wait_chg(v, gap);
      chk("col_dec", 16'(v), 16'd251);
      step(3);
      chk("col_pre", 16'(env_level), 16'd251);
      note_code = 8'h00;
      step();
      chk("col_stop_lvl", 16'(env_level), 16'd251);
      chk("col_stop_busy", 16'(busy), 16'd1);
      step(3);
      chk("col_stop_hold", 16'(env_level), 16'd251);
      step();
      chk("col_rel_tick", 16'(env_level), 16'd243);

      // Note start exactly on the tick edge.
      step(3);
      note_code = 8'h33;
      step();
      chk("col_start_lvl", 16'(env_level), 16'd243);
      step(3);
      chk("col_start_hold", 16'(env_level), 16'd243);
      step();
      chk("col_atk_sat", 16'(env_level), 16'd255);
      step(4);
      chk("col_decay", 16'(env_level), 16'd251);

      g_lvl = 8'd255; g_vol = 2'd0;
      step();
      gcount(n);
      chk("gate_255_v0", 16'(n), 16'd31);
      g_vol = 2'd3;
      step();
      gcount(n);
      chk("gate_255_v3", 16'(n), 16'd256);
      g_lvl = 8'd0;
      step();
      gcount(n);
      chk("gate_0_v3", 16'(n), 16'd0);
      g_lvl = 8'd100; g_vol = 2'd2;
      step();
      gcount(n);
      chk("gate_100_v2", 16'(n), 16'd50);

      // Asynchronous reset in the middle of an attack.
      note_code = 8'h12;
      wait_chg(v, gap);
      chk("ar_busy", 16'(busy), 16'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_env", 16'(env_level), 16'd0);
      chk("ar_out", 16'(out), 16'd1);
      chk("ar_busy0", 16'(busy), 16'd0);
      step();
      rst = 1'b1;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
